// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus widths, FSM encoding and master IDs for mem_arbiter.
package mem_arbiter_pkg;
    localparam int REG_W      = 32;
    localparam int MEM_TYPE_W = 3;
    localparam int CNT_W      = 8;

    typedef logic [REG_W-1:0]      reg_bus_t;
    typedef logic [MEM_TYPE_W-1:0] mem_type_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_G_CORE = 2'd1,
        ARB_G_DBG  = 2'd2
    } arb_state_e;

    localparam logic ARB_CORE = 1'b0;
    localparam logic ARB_DBG  = 1'b1;
endpackage

// File: rtl/mem_arbiter_timer.sv
// mem_arb_timer: saturating busy-cycle counter; o_timeout fires when the count reaches
// TIMEOUT_CYC during an enabled cycle. TIMEOUT_CYC = 0 disables it.
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam bit TO_EN = TIMEOUT_CYC != 0;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_timeout = TO_EN && i_en && r_cnt == LIMIT;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the core and the debug path, one whole
// transaction per grant, with busy-timeout abort. MEM_ARB_RR_EN selects round-robin ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      c_rmem,
    input  logic      c_wmem,
    input  reg_bus_t  c_addr,
    input  reg_bus_t  c_wdata,
    input  mem_type_t c_type,
    input  logic      c_sign,
    output reg_bus_t  c_rdata,
    output logic      c_busy,
    output logic      c_err,
    input  logic      d_rmem,
    input  logic      d_wmem,
    input  reg_bus_t  d_addr,
    input  reg_bus_t  d_wdata,
    input  mem_type_t d_type,
    input  logic      d_sign,
    output reg_bus_t  d_rdata,
    output logic      d_busy,
    output logic      d_err,
    output logic      mem_rmem,
    output logic      mem_wmem,
    output reg_bus_t  mem_addr,
    output reg_bus_t  mem_wdata,
    output mem_type_t mem_type,
    output logic      mem_sign,
    input  reg_bus_t  mem_rdata,
    input  logic      mem_busy
);
    arb_state_e r_state, w_next;
    logic w_c_req, w_d_req, w_g_c, w_g_d, w_grant, w_req, w_pick_d, w_timeout;

    assign w_c_req = c_rmem | c_wmem;
    assign w_d_req = d_rmem | d_wmem;
    assign w_g_c   = r_state == ARB_G_CORE;
    assign w_g_d   = r_state == ARB_G_DBG;
    assign w_grant = w_g_c | w_g_d;
    assign w_req   = w_g_c ? w_c_req : w_d_req;

`ifdef MEM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_last <= ARB_CORE;
        else if (r_state == ARB_IDLE && (w_c_req || w_d_req))
            r_last <= w_pick_d ? ARB_DBG : ARB_CORE;
    end

    assign w_pick_d = w_d_req && (!w_c_req || r_last == ARB_CORE);
`else
    assign w_pick_d = w_d_req;
`endif

    // Only a still-requesting master waiting on the slave accumulates timeout cycles
    mem_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (r_state == ARB_IDLE),
        .i_en     (w_grant && w_req && mem_busy),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ARB_IDLE)
            w_next = (w_c_req || w_d_req) ? (w_pick_d ? ARB_G_DBG : ARB_G_CORE) : ARB_IDLE;
        else if (!w_grant || !w_req || !mem_busy || w_timeout)
            w_next = ARB_IDLE;
    end

    always_comb begin
        mem_rmem  = w_g_c ? c_rmem  : w_g_d ? d_rmem  : 1'b0;
        mem_wmem  = w_g_c ? c_wmem  : w_g_d ? d_wmem  : 1'b0;
        mem_addr  = w_g_c ? c_addr  : w_g_d ? d_addr  : '0;
        mem_wdata = w_g_c ? c_wdata : w_g_d ? d_wdata : '0;
        mem_type  = w_g_c ? c_type  : w_g_d ? d_type  : '0;
        mem_sign  = w_g_c ? c_sign  : w_g_d ? d_sign  : 1'b0;
    end

    assign c_busy  = w_c_req && !(w_g_c && (!mem_busy || w_timeout));
    assign d_busy  = w_d_req && !(w_g_d && (!mem_busy || w_timeout));
    assign c_err   = w_g_c && w_timeout;
    assign d_err   = w_g_d && w_timeout;
    assign c_rdata = (w_g_c && !w_timeout) ? mem_rdata : '0;
    assign d_rdata = (w_g_d && !w_timeout) ? mem_rdata : '0;
endmodule
